// File: rtl/top2_clap_light_if.sv
// SPI link between the clap-light controller (master) and the audio ADC (slave).
interface top2_clap_light_if;
  logic spi_clock;
  logic spi_chipselect;
  logic spi_data;

  modport master (
    output spi_clock,
    output spi_chipselect,
    input  spi_data
  );

  modport slave (
    input  spi_clock,
    input  spi_chipselect,
    output spi_data
  );
endinterface

// File: rtl/top2_clap_light.sv
// Clap-clap light controller: polls an SPI ADC for audio samples, detects amplitude
// peaks and toggles the light output when two claps land within a bounded window.
module top2_clap_light #(
  parameter int                      SAMPLE_WIDTH = 16,
  parameter int                      SPI_DIV      = 4,
  parameter int                      CS_IDLE      = 8,
  parameter logic [SAMPLE_WIDTH-1:0] MIDSCALE     = 16'h8000,
  parameter logic [SAMPLE_WIDTH-1:0] THRESHOLD    = 16'h4000,
  parameter int                      HOLDOFF      = 8,
  parameter int                      WINDOW       = 64
) (
  input  logic               inclock,
  input  logic               inreset_n,
  top2_clap_light_if.master  spi,
  output logic               toglite_state
);

  localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int BIT_W = $clog2(SAMPLE_WIDTH);
  localparam int GAP_W = $clog2(CS_IDLE);
  localparam int CNT_MAX = (HOLDOFF > WINDOW) ? HOLDOFF : WINDOW;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SPI_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(SAMPLE_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(CS_IDLE - 2);
  localparam logic [CNT_W-1:0] HOLDOFF_C  = CNT_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] WINDOW_C   = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} spi_state_t;
  typedef enum logic [1:0] {WAIT1, HOLD1, WIN, HOLD2} clap_state_t;

  spi_state_t              spi_state;
  logic [DIV_W-1:0]        half_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic [SAMPLE_WIDTH-2:0] shift_reg;
  logic [SAMPLE_WIDTH-1:0] sample;
  logic                    sample_valid;

  clap_state_t             clap_state;
  logic [CNT_W-1:0]        clap_cnt;
  logic [SAMPLE_WIDTH-1:0] mag;
  logic                    peak;

  // SPI master: a FRAME entered with chipselect still high first drops it; the last
  // rising spi_clock edge closes the frame and delivers the word in the same cycle.
  always_ff @(posedge inclock) begin
    if (!inreset_n) begin
      spi_state          <= IDLE;
      spi.spi_clock      <= 1'b1;
      spi.spi_chipselect <= 1'b1;
      half_cnt           <= '0;
      bit_cnt            <= '0;
      gap_cnt            <= '0;
      shift_reg          <= '0;
      sample             <= '0;
      sample_valid       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (spi_state)
        IDLE: spi_state <= FRAME;
        FRAME: begin
          if (spi.spi_chipselect) begin
            spi.spi_chipselect <= 1'b0;
            half_cnt           <= '0;
            bit_cnt            <= '0;
          end else if (half_cnt == DIV_LAST) begin
            half_cnt <= '0;
            if (spi.spi_clock) begin
              spi.spi_clock <= 1'b0;
            end else begin
              spi.spi_clock <= 1'b1;
              shift_reg     <= {shift_reg[SAMPLE_WIDTH-3:0], spi.spi_data};
              bit_cnt       <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                spi.spi_chipselect <= 1'b1;
                sample             <= {shift_reg, spi.spi_data};
                sample_valid       <= 1'b1;
                gap_cnt            <= '0;
                spi_state          <= GAP;
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) spi_state <= FRAME;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: spi_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mag = '0;
    if (sample < MIDSCALE) mag = MIDSCALE - sample;
    else mag = sample - MIDSCALE;
    peak = (mag >= THRESHOLD);
  end

  // Clap detector: holdoff swallows the ringing of each clap, the window bounds the gap.
  always_ff @(posedge inclock) begin
    if (!inreset_n) begin
      clap_state    <= WAIT1;
      clap_cnt      <= '0;
      toglite_state <= 1'b0;
    end else if (sample_valid) begin
      case (clap_state)
        WAIT1: begin
          if (peak) begin
            clap_state <= HOLD1;
            clap_cnt   <= HOLDOFF_C;
          end
        end
        HOLD1: begin
          if (clap_cnt <= CNT_ONE) begin
            clap_state <= WIN;
            clap_cnt   <= WINDOW_C;
          end else begin
            clap_cnt <= clap_cnt - 1'b1;
          end
        end
        WIN: begin
          if (peak) begin
            toglite_state <= ~toglite_state;
            clap_state    <= HOLD2;
            clap_cnt      <= HOLDOFF_C;
          end else if (clap_cnt <= CNT_ONE) begin
            clap_state <= WAIT1;
          end else begin
            clap_cnt <= clap_cnt - 1'b1;
          end
        end
        HOLD2: begin
          if (clap_cnt <= CNT_ONE) clap_state <= WAIT1;
          else clap_cnt <= clap_cnt - 1'b1;
        end
        default: clap_state <= WAIT1;
      endcase
    end
  end

endmodule

// File: tb/tb_top2_clap_light.sv
// Randomized bench for top2_clap_light: plays an SPI ADC and compares the light
// output against a sample-index based model of the double-clap rules.
module tb_top2_clap_light;

  localparam int SAMPLE_WIDTH = 16;
  localparam int SPI_DIV      = 4;
  localparam int CS_IDLE      = 8;
  localparam int HOLDOFF      = 8;
  localparam int WINDOW       = 64;
  localparam int WAIT_LIMIT   = 300;
  localparam logic [15:0] SILENCE = 16'h8000;
  localparam logic [15:0] CLAP    = 16'hF000;

  logic inclock;
  logic inreset_n;
  logic toglite_state;

  top2_clap_light_if spi_bus ();

  top2_clap_light dut (
    .inclock       (inclock),
    .inreset_n     (inreset_n),
    .spi           (spi_bus),
    .toglite_state (toglite_state)
  );

  always #5 inclock = ~inclock;

  int checks   = 0;
  int failures = 0;

  // Reference model state: clap history kept as sample indices
  int model_idx;
  int hold_until;
  int first_at;
  bit armed;
  bit model_light;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int absDev(input logic [15:0] s);
    int d;
    d = int'(s) - 32768;
    return (d < 0) ? -d : d;
  endfunction

  task automatic modelReset();
    model_idx   = 0;
    hold_until  = -1;
    first_at    = -1000;
    armed       = 0;
    model_light = 0;
  endtask

  task automatic modelSample(input logic [15:0] s);
    if (absDev(s) >= 16384 && model_idx > hold_until) begin
      if (armed && model_idx <= first_at + HOLDOFF + WINDOW) begin
        model_light = !model_light;
        armed = 0;
      end else begin
        armed = 1;
        first_at = model_idx;
      end
      hold_until = model_idx + HOLDOFF;
    end
    model_idx++;
  endtask

  task automatic waitLevel(input bit use_clk, input logic level, input string tag);
    int n;
    n = 0;
    while (((use_clk ? spi_bus.spi_clock : spi_bus.spi_chipselect) !== level) && n < WAIT_LIMIT) begin
      @(negedge inclock);
      n++;
    end
    checkOutput(tag, use_clk ? spi_bus.spi_clock : spi_bus.spi_chipselect, level);
  endtask

  // Plays one ADC frame: new bit on every falling spi_clock, then checks the result
  task automatic applyStimulus(input logic [15:0] word);
    waitLevel(0, 1'b0, "wait_cs_low");
    for (int i = SAMPLE_WIDTH - 1; i >= 0; i--) begin
      waitLevel(1, 1'b1, "wait_clk_high");
      waitLevel(1, 1'b0, "wait_clk_low");
      spi_bus.spi_data = word[i];
    end
    waitLevel(0, 1'b1, "wait_cs_high");
    checkOutput("sample_valid", dut.sample_valid, 1);
    checkOutput("sample_word", dut.sample, word);
    checkOutput("magnitude", dut.mag, absDev(word));
    modelSample(word);
    @(negedge inclock);
    checkOutput("light_state", toglite_state, model_light);
  endtask

  task automatic runPattern(input int n, input int ia, input logic [15:0] va,
                            input int ib, input logic [15:0] vb,
                            input int ic, input logic [15:0] vc);
    for (int i = 0; i < n; i++) begin
      if (i == ia) applyStimulus(va);
      else if (i == ib) applyStimulus(vb);
      else if (i == ic) applyStimulus(vc);
      else applyStimulus(SILENCE);
    end
  endtask

  task automatic doReset();
    int n;
    inreset_n = 1'b0;
    repeat (3) begin
      @(negedge inclock);
      checkOutput("rst_cs", spi_bus.spi_chipselect, 1);
      checkOutput("rst_clk", spi_bus.spi_clock, 1);
      checkOutput("rst_light", toglite_state, 0);
    end
    inreset_n = 1'b1;
    modelReset();
    n = 0;
    while (spi_bus.spi_chipselect !== 1'b0 && n < 20) begin
      @(negedge inclock);
      n++;
      checkOutput("light_after_rst", toglite_state, 0);
    end
    checkOutput("cs_fall_delay", n, 2);
  endtask

  // Framing monitor: chipselect low length, clock pulses, first fall and gap length
  logic prev_cs = 1'b1;
  logic prev_clk = 1'b1;
  int low_len, high_len, rises, first_fall;
  bit seen_fall = 0;
  bit seen_rise = 0;

  always @(negedge inclock) begin
    int rise;
    rise = (prev_clk === 1'b0 && spi_bus.spi_clock === 1'b1) ? 1 : 0;
    if (inreset_n !== 1'b1) begin
      seen_fall = 0;
      seen_rise = 0;
    end else begin
      if (spi_bus.spi_chipselect === 1'b0 && prev_cs === 1'b1) begin
        if (seen_rise) checkOutput("gap_len", high_len, CS_IDLE);
        seen_fall  = 1;
        low_len    = 0;
        rises      = 0;
        first_fall = -1;
      end
      if (spi_bus.spi_chipselect === 1'b1 && prev_cs === 1'b0 && seen_fall) begin
        checkOutput("frame_len", low_len, 2 * SAMPLE_WIDTH * SPI_DIV);
        checkOutput("clk_rises", rises + rise, SAMPLE_WIDTH);
        checkOutput("first_clk_fall", first_fall, SPI_DIV);
        seen_rise = 1;
        high_len  = 0;
      end
      if (spi_bus.spi_chipselect === 1'b0) begin
        if (spi_bus.spi_clock === 1'b0 && prev_clk === 1'b1 && first_fall < 0) first_fall = low_len;
        low_len++;
        rises += rise;
      end else begin
        high_len++;
      end
    end
    prev_cs  = spi_bus.spi_chipselect;
    prev_clk = spi_bus.spi_clock;
  end

  initial begin
    logic [15:0] edge_words [5];
    logic [15:0] w;
    inclock = 1'b0;
    inreset_n = 1'b0;
    spi_bus.spi_data = 1'b0;
    modelReset();
    doReset();

    applyStimulus(16'hA5C3);
    runPattern(80, 5, CLAP, -1, SILENCE, -1, SILENCE);
    runPattern(40, 10, CLAP, 30, CLAP, -1, SILENCE);
    runPattern(40, 10, CLAP, 30, CLAP, -1, SILENCE);
    runPattern(60, 10, CLAP, 30, CLAP, 50, CLAP);

    for (int i = 0; i < 80; i++) applyStimulus(16'(32'h4001 + $urandom_range(0, 32'h7FFE)));

    runPattern(40, 10, 16'h0000, 12, CLAP, 30, CLAP);

    edge_words = '{16'h4001, 16'hBFFF, 16'h4000, 16'h8000, 16'hC000};
    foreach (edge_words[i]) applyStimulus(edge_words[i]);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0)
        w = $urandom_range(0, 1) ? 16'($urandom_range(0, 32'h4000)) : 16'($urandom_range(32'hC000, 32'hFFFF));
      else
        w = 16'(32'h4001 + $urandom_range(0, 32'h7FFE));
      applyStimulus(w);
    end

    if (!model_light) runPattern(40, 10, CLAP, 30, CLAP, -1, SILENCE);

    waitLevel(0, 1'b0, "wait_cs_low_mid");
    repeat (40) @(negedge inclock);
    doReset();
    runPattern(40, 10, CLAP, 30, CLAP, -1, SILENCE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
